// File: rtl/encoder8to3_pend.sv
// encoder8to3_pend
//   Registered 8-to-3 priority encoder with a sticky pending register.
//   Request pulses on D are collected into pend_q. The index of the
//   top-priority pending bit is presented on Y with V. It is held until the
//   consumer acknowledges it, and an acknowledge clears exactly that bit.
//
// Parameters
//   HIGH_FIRST : 1 -> bit 7 has the highest priority, 0 -> bit 0 has the highest priority
//
// Ports
//   clk  : clock; all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   E    : enable; 0 freezes capture and ack, and blanks the outputs
//   D    : request lines; a high bit sets its pending bit
//   ack  : consumer acknowledge; clears the bit currently shown on Y
//   Y    : index of the top-priority pending bit (000 when V=0)
//   V    : at least one pending bit and E=1
//   M    : more than one pending bit and E=1
//   OVF  : sticky; a request hit a bit that was already pending
module encoder8to3_pend #(
    parameter int unsigned HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] D,
    input  logic       ack,
    output logic [2:0] Y,
    output logic       V,
    output logic       M,
    output logic       OVF
);

    logic [7:0] pend_q, pend_d;
    logic       ovf_q, ovf_d;
    logic [7:0] clr;
    logic [2:0] idx;
    logic [2:0] k;
    logic       xfer;

    // Scan from lowest to highest priority so that the last hit wins.
    always_comb begin
        idx = '0;
        k   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (HIGH_FIRST != 0) begin
                k = 3'(i);
            end else begin
                k = 3'(7 - i);
            end
            if (pend_q[k]) begin
                idx = k;
            end
        end
    end

    // Outputs depend only on the registered state and E.
    always_comb begin
        V = E & (|pend_q);
        Y = V ? idx : '0;
        // x & (x-1) clears the lowest set bit, so a nonzero result means at least two bits are set.
        M = E & (|(pend_q & (pend_q - 8'd1)));
    end

    // A set from D has priority over a clear from ack: clr is applied
    // first and D is ORed in afterwards.
    always_comb begin
        xfer   = V & ack;
        clr    = xfer ? (8'd1 << idx) : '0;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (E) begin
            pend_d = (pend_q & ~clr) | D;
            ovf_d  = ovf_q | (|(D & pend_q & ~clr));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign OVF = ovf_q;

endmodule

// File: doc/encoder8to3_pend.md
Name: encoder8to3_pend

Overview:
- Registered 8-to-3 priority encoder. It is the inverse of the 3-to-8 decoder: it turns one-hot or multi-hot request lines back into a 3-bit index.
- Requests are captured into a sticky pending register. The encoded index of the top-priority pending bit is presented with a valid flag and held until acknowledged.
- Sits on the return path of decoder-driven select lines: interrupt/event collection, handing an index to a consumer via valid/ack.

Parameters:
HIGH_FIRST, 1, 1: bit 7 is highest priority; 0: bit 0 is highest priority.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
E    input  1  enable; 0 freezes capture, output and ack
D    input  8  request lines; any bit high for one cycle sets its pending bit
ack  input  1  consumer acknowledge; clears the bit currently encoded on Y
Y    output 3  encoded index of top-priority pending bit
V    output 1  at least one pending bit and E=1
M    output 1  more than one pending bit and E=1
OVF  output 1  sticky: a request hit an already-pending bit

Behaviour:
- Reset (async, rst=1): pend=8'h00, OVF=0. Outputs immediately Y=3'b000, V=0, M=0, OVF=0. This holds for any rst assertion mid-operation; all pending requests are discarded.
- State: pend[7:0], OVF. Outputs Y/V/M are combinational decodes of pend and E only. No combinational path from D or ack to any output.
- Latency:
  - D bit high at edge k with E=1 sets pend at edge k; V/Y reflect it in the cycle after edge k (1-cycle latency).
- Encoding: Y = index of highest-priority set pend bit, per HIGH_FIRST.
  - Y=3'b000 whenever V=0.
  - Y may change while V=1 if a higher-priority request arrives; the consumer reads Y in the ack cycle.
- Handshake: a cycle with E=1, V=1, ack=1 is a transfer.
  - At the next edge, pend bit Y is cleared.
  - ack with V=0 or E=0 has no effect.
- Next-state, when E=1: pend_next = (pend & ~clr) | D.
  - clr is one-hot(Y) on a transfer, else 0.
  - Same bit set by D and cleared by ack in the same cycle: set wins, bit stays pending, no OVF.
- OVF is set at an edge when E=1 and (D & pend & ~clr) != 0. It stays 1 until rst.
- E=0: D ignored (not captured, no OVF), ack ignored, pend held. Outputs forced V=0, M=0, Y=3'b000. When E returns to 1, held pending bits reappear the same cycle.
- Multiple D bits in one cycle: all captured. They are serviced in priority order, one per transfer. Back-to-back acks drain one bit per cycle.
- M=1 iff popcount(pend)>=2 and E=1.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
1. Reset then idle: rst=1 for 20 ns, then E=1, D=0 -> Y=000, V=0, M=0, OVF=0.
2. Single request per index: E=1, pulse D=8'b0000_0001<<i for i=0..7, ack on the next cycle -> Y=i with V=1 one cycle after the pulse; V=0 one cycle after the ack. This mirrors the decoder sweep.
3. Multi-hot drain: D=8'b1010_0100 one cycle, then ack held high -> with HIGH_FIRST=1, Y sequence 7,5,2 on consecutive cycles. M=1,1,0 across that sequence, then V=0. With HIGH_FIRST=0: 2,5,7.
4. Pre-emption: pend={bit 1}, V=1, Y=1 and no ack; pulse D bit 6 -> Y=6 next cycle. Ack -> Y=1. Ack -> V=0.
5. Overflow and set-wins: D bit 3 twice with no ack -> OVF=1 after the 2nd edge, bit 3 still single-pending. Separately, D bit 3 in the same cycle as the ack of Y=3 -> V stays 1, Y=3, OVF unchanged (0).
6. Enable and reset mid-op: pend=8'h81, drop E -> V=0, Y=000; pulse D=8'h10 and ack meanwhile. Raise E -> Y=7, pend=8'h81 (bit 4 not captured). Assert rst asynchronously between edges -> V=0, OVF=0 immediately.
